sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the successor to the peripheral-bus FIFO. Used in UART/SPI/I2C peripherals and bus bridges. Over its predecessor it adds:
- full-DEPTH usage and non-power-of-2 depths;
- occupancy count and programmable almost-full/almost-empty flags;
- optional first-word-fall-through (FWFT) read mode;
- synchronous flush;
- sticky overflow/underflow error flags.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo.sv | 154 +++++++++++++++
 tb/tb_sync_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and helpers for the sync_fifo block.
//   fifo_rd_mode_e : read-port behaviour selected by the FWFT parameter
//   cnt_width()    : bits needed to hold an occupancy of 0..depth
package sync_fifo_pkg;

    typedef enum logic {
        RD_REGISTERED = 1'b0,
        RD_FWFT       = 1'b1
    } fifo_rd_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: storage array for sync_fifo, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk       : write clock, rising edge
//   i_wr_en   : write strobe
//   i_wr_addr : write address (0..DEPTH-1)
//   i_wr_data : write data
//   i_rd_addr : read address (0..DEPTH-1)
//   o_rd_data : read data, combinational from i_rd_addr
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, optional first-word-fall-through read,
// synchronous flush and sticky overflow/underflow flags.
//   clk, rst_n       : clock (rising edge), async active-low reset
//   flush_i          : synchronous clear of pointers/count (and read data)
//   wr_en_i, write_data_i : push request and data
//   rd_en_i, read_data_o  : pop request and data
//   full_o, empty_o, almost_full_o, almost_empty_o : decoded from count_o
//   count_o          : current occupancy 0..DEPTH
//   err_clr_i        : clears overflow_o/underflow_o
//   overflow_o, underflow_o : sticky rejected-push / rejected-pop flags
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic                            wr_en_i,
    input  logic [WIDTH-1:0]                write_data_i,
    input  logic                            rd_en_i,
    output logic [WIDTH-1:0]                read_data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic                            almost_full_o,
    output logic                            almost_empty_o,
    output logic [cnt_width(DEPTH)-1:0]     count_o,
    input  logic                            err_clr_i,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam fifo_rd_mode_e RD_MODE = (FWFT != 0) ? RD_FWFT : RD_REGISTERED;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    if (DEPTH < 2) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
        $error("sync_fifo: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
        $error("sync_fifo: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [WIDTH-1:0] w_mem_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags depend on the count register only, never on the request inputs.
    assign count_o        = r_count;
    assign full_o         = (r_count == FULL_CNT);
    assign empty_o        = (r_count == '0);
    assign almost_full_o  = (r_count >= AF_CNT);
    assign almost_empty_o = (r_count <= AE_CNT);
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

    // A pop on empty never sees a same-cycle push; a push on full is allowed
    // only when a pop frees the slot in the same cycle.
    assign w_rd_acc = rd_en_i && !empty_o;
    assign w_wr_acc = wr_en_i && (!full_o || w_rd_acc);

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc && !flush_i),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (write_data_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_mem_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky errors: a new rejection wins over a same-cycle clear; a flush
    // cycle reports nothing because no request is evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (!flush_i && wr_en_i && !w_wr_acc) ||
                           (r_overflow && !err_clr_i);
            r_underflow <= (!flush_i && rd_en_i && !w_rd_acc) ||
                           (r_underflow && !err_clr_i);
        end
    end

    if (RD_MODE == RD_REGISTERED) begin : g_rd_reg
        logic [WIDTH-1:0] r_rd_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_data <= '0;
            end else if (flush_i) begin
                r_rd_data <= '0;
            end else if (w_rd_acc) begin
                r_rd_data <= w_mem_rd;
            end
        end

        assign read_data_o = r_rd_data;
    end else begin : g_rd_fwft
        assign read_data_o = empty_o ? '0 : w_mem_rd;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo using three instances:
//   u_a : DEPTH=5, FWFT=0 (fill/drain, full push+pop, errors, flush, reset)
//   u_b : DEPTH=4, FWFT=1 (fall-through head, push into empty with pop)
//   u_c : DEPTH=8, AF_LEVEL=4, AE_LEVEL=1 (threshold flags over 0->8->0)
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A
    logic       a_flush, a_wr, a_rd, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_cnt;

    // Instance B
    logic       b_flush, b_wr, b_rd, b_clr;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_cnt;

    // Instance C
    logic       c_flush, c_wr, c_rd, c_clr;
    logic [7:0] c_din, c_dout;
    logic       c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [3:0] c_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] drain_exp [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'hAA};

    sync_fifo #(.DEPTH(5), .WIDTH(8), .FWFT(0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .wr_en_i(a_wr),
        .write_data_i(a_din), .rd_en_i(a_rd), .read_data_o(a_dout),
        .full_o(a_full), .empty_o(a_empty), .almost_full_o(a_af),
        .almost_empty_o(a_ae), .count_o(a_cnt), .err_clr_i(a_clr),
        .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    sync_fifo #(.DEPTH(4), .WIDTH(8), .FWFT(1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .wr_en_i(b_wr),
        .write_data_i(b_din), .rd_en_i(b_rd), .read_data_o(b_dout),
        .full_o(b_full), .empty_o(b_empty), .almost_full_o(b_af),
        .almost_empty_o(b_ae), .count_o(b_cnt), .err_clr_i(b_clr),
        .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    sync_fifo #(.DEPTH(8), .WIDTH(8), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush_i(c_flush), .wr_en_i(c_wr),
        .write_data_i(c_din), .rd_en_i(c_rd), .read_data_o(c_dout),
        .full_o(c_full), .empty_o(c_empty), .almost_full_o(c_af),
        .almost_empty_o(c_ae), .count_o(c_cnt), .err_clr_i(c_clr),
        .overflow_o(c_ovf), .underflow_o(c_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed 1ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_flush, a_wr, a_rd, a_clr} = '0; a_din = '0;
        {b_flush, b_wr, b_rd, b_clr} = '0; b_din = '0;
        {c_flush, c_wr, c_rd, c_clr} = '0; c_din = '0;
        #12;
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("a_rst_cnt",   a_cnt,   0);
        chk("a_rst_empty", a_empty, 1);
        chk("a_rst_full",  a_full,  0);
        chk("a_rst_ae",    a_ae,    1);
        chk("a_rst_af",    a_af,    0);
        chk("a_rst_dout",  a_dout,  0);
        chk("a_rst_ovf",   a_ovf,   0);
        chk("a_rst_udf",   a_udf,   0);
        chk("b_rst_dout",  b_dout,  0);
        chk("b_rst_empty", b_empty, 1);

        // Fill DEPTH=5 with 0x10..0x14
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1;
            a_din = 8'(8'h10 + i);
            tick();
        end
        chk("a_fill_full", a_full, 1);
        chk("a_fill_cnt",  a_cnt,  5);
        chk("a_fill_ovf",  a_ovf,  0);
        a_din = 8'h99;
        tick();
        a_wr = 1'b0;
        chk("a_ovf_set", a_ovf, 1);
        chk("a_ovf_cnt", a_cnt, 5);

        // Drain in order, each word one edge after rd_en_i
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            tick();
            chk("a_drain_data", a_dout, 32'(8'h10 + i));
        end
        a_rd = 1'b0;
        chk("a_drain_empty", a_empty, 1);
        chk("a_drain_cnt",   a_cnt,   0);

        // Clear overflow, refill, then push+pop while full
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("a_ovf_clr", a_ovf, 0);
        for (int i = 0; i < 5; i++) begin
            a_wr = 1'b1;
            a_din = 8'(8'h20 + i);
            tick();
        end
        a_din = 8'hAA;
        a_rd = 1'b1;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b0;
        chk("a_pp_data", a_dout, 8'h20);
        chk("a_pp_cnt",  a_cnt,  5);
        chk("a_pp_ovf",  a_ovf,  0);
        chk("a_pp_full", a_full, 1);
        for (int i = 0; i < 5; i++) begin
            a_rd = 1'b1;
            tick();
            chk("a_pp_drain", a_dout, 32'(drain_exp[i]));
        end
        a_rd = 1'b0;
        chk("a_pp_empty", a_empty, 1);

        // Underflow, clear, clear racing a new bad pop
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        chk("a_udf_set",  a_udf,  1);
        chk("a_udf_hold", a_dout, 8'hAA);
        a_clr = 1'b1;
        tick();
        chk("a_udf_clr", a_udf, 0);
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        a_clr = 1'b0;
        chk("a_udf_setwins", a_udf, 1);
        tick();
        chk("a_udf_sticky", a_udf, 1);

        // Flush at count 3 together with a push
        for (int i = 1; i <= 3; i++) begin
            a_wr = 1'b1;
            a_din = 8'(i);
            tick();
        end
        chk("a_pre_flush_cnt", a_cnt, 3);
        a_din = 8'h55;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_wr = 1'b0;
        chk("a_flush_cnt",   a_cnt,   0);
        chk("a_flush_empty", a_empty, 1);
        chk("a_flush_ovf",   a_ovf,   0);
        chk("a_flush_dout",  a_dout,  0);
        a_wr = 1'b1;
        a_din = 8'h77;
        tick();
        a_wr = 1'b0;
        a_rd = 1'b1;
        tick();
        a_rd = 1'b0;
        chk("a_post_flush_data", a_dout, 8'h77);
        a_wr = 1'b1;
        a_din = 8'h78;
        tick();
        a_wr = 1'b0;
        chk("a_pre_rst_cnt", a_cnt, 1);

        // FWFT: fall-through without rd_en_i
        b_wr = 1'b1;
        b_din = 8'h3C;
        tick();
        b_wr = 1'b0;
        chk("b_fwft_data",  b_dout,  8'h3C);
        chk("b_fwft_empty", b_empty, 0);
        tick();
        chk("b_fwft_hold", b_dout, 8'h3C);
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("b_pop_data",  b_dout,  0);
        chk("b_pop_empty", b_empty, 1);
        // Push into empty with same-cycle pop: pop rejected
        b_wr = 1'b1;
        b_din = 8'h5A;
        b_rd = 1'b1;
        tick();
        b_rd = 1'b0;
        chk("b_pe_udf",  b_udf,  1);
        chk("b_pe_cnt",  b_cnt,  1);
        chk("b_pe_data", b_dout, 8'h5A);
        b_din = 8'h6B;
        tick();
        b_wr = 1'b0;
        chk("b_two_cnt",  b_cnt,  2);
        chk("b_two_head", b_dout, 8'h5A);
        b_rd = 1'b1;
        tick();
        chk("b_next_head", b_dout, 8'h6B);
        tick();
        b_rd = 1'b0;
        chk("b_last_data",  b_dout,  0);
        chk("b_last_empty", b_empty, 1);

        // Threshold flags over 0 -> 8 -> 0
        for (int i = 1; i <= 8; i++) begin
            c_wr = 1'b1;
            c_din = 8'(i);
            tick();
            chk("c_up_cnt", c_cnt, 32'(i));
            chk("c_up_af",  c_af,  32'(i >= 4));
            chk("c_up_ae",  c_ae,  32'(i <= 1));
        end
        c_wr = 1'b0;
        chk("c_full", c_full, 1);
        for (int j = 0; j < 8; j++) begin
            c_rd = 1'b1;
            tick();
            chk("c_dn_data", c_dout, 32'(j + 1));
            chk("c_dn_cnt",  c_cnt,  32'(7 - j));
            chk("c_dn_af",   c_af,   32'((7 - j) >= 4));
            chk("c_dn_ae",   c_ae,   32'((7 - j) <= 1));
        end
        c_rd = 1'b0;
        chk("c_empty", c_empty, 1);

        // Asynchronous reset pulse between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_arst_cnt",   a_cnt,   0);
        chk("a_arst_empty", a_empty, 1);
        chk("a_arst_dout",  a_dout,  0);
        chk("a_arst_udf",   a_udf,   0);
        chk("b_arst_udf",   b_udf,   0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("a_post_rst_empty", a_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
